// File: rtl/writeback_queue.sv
// writeback_queue
//   Circular FIFO of pending register-file writes sitting between an
//   execution pipeline and the register file. Each entry holds
//   {register index, value}. The head entry is popped into a registered
//   write port whenever the queue is non-empty and the register file is
//   not stalled.
//
// Parameters
//   RegisterSize : data width of every queued value
//   Depth        : number of queue entries (power of two, >= 2)
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous active-low reset
//   inValid        : producer offers {inRegister, inValue}
//   inReady        : queue accepts a result (not full)
//   inRegister     : destination register index of offered result
//   inValue        : offered result value
//   stall          : register file cannot take a write; hold the head
//   regWriteEnable : registered write strobe to the register file
//   writeRegister  : registered write index
//   writeValue     : registered write data
//   count          : number of occupied entries
//   lookupRegister : register index probed by decode
//   lookupHit      : probed register has a pending write
//   lookupValue    : value of the youngest pending write to lookupRegister
//
// Configuration
//   WB_BYPASS_EN : when defined, builds the lookup/bypass comparators.
//                  When undefined, lookupHit/lookupValue are tied to 0.

module writeback_queue #(
  parameter int unsigned RegisterSize = 32,
  parameter int unsigned Depth        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [3:0]                inRegister,
  input  logic [RegisterSize-1:0]   inValue,
  input  logic                      stall,
  output logic                      regWriteEnable,
  output logic [3:0]                writeRegister,
  output logic [RegisterSize-1:0]   writeValue,
  output logic [$clog2(Depth):0]    count,
  input  logic [3:0]                lookupRegister,
  output logic                      lookupHit,
  output logic [RegisterSize-1:0]   lookupValue
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  // Entry storage; only occupied slots are ever observed, so no reset needed.
  logic [3:0]              reg_mem_q [Depth];
  logic [RegisterSize-1:0] val_mem_q [Depth];

  logic [PtrW-1:0]         head_q, head_d;
  logic [PtrW-1:0]         tail_q, tail_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    we_q, we_d;
  logic [3:0]              wr_q, wr_d;
  logic [RegisterSize-1:0] wv_q, wv_d;

  logic push;
  logic pop;

  // inReady depends on registered count only, so a pop in a full cycle
  // cannot open a slot for a same-cycle push.
  assign inReady = (count_q != FullCount);
  assign push    = inValid && inReady;
  // Pop decision uses pre-edge count: an entry pushed at this edge is not
  // visible to the pop until the next edge (no fall-through).
  assign pop     = (count_q != '0) && !stall;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we_d    = 1'b0;
    wr_d    = wr_q;
    wv_d    = wv_q;

    if (push) begin
      tail_d = tail_q + PtrOne;
    end

    if (pop) begin
      head_d = head_q + PtrOne;
      we_d   = 1'b1;
      wr_d   = reg_mem_q[head_q];
      wv_d   = val_mem_q[head_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      wr_q    <= '0;
      wv_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      wv_q    <= wv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem_q[tail_q] <= inRegister;
      val_mem_q[tail_q] <= inValue;
    end
  end

  assign regWriteEnable = we_q;
  assign writeRegister  = wr_q;
  assign writeValue     = wv_q;
  assign count          = count_q;

`ifdef WB_BYPASS_EN
  logic                    hit_c;
  logic [RegisterSize-1:0] val_c;
  logic [PtrW-1:0]         slot;

  // Scan from oldest to youngest so later matches override earlier ones:
  // output register first, then queue entries from head towards tail.
  always_comb begin
    hit_c = 1'b0;
    val_c = '0;
    slot  = '0;
    if (we_q && (wr_q == lookupRegister)) begin
      hit_c = 1'b1;
      val_c = wv_q;
    end
    for (int unsigned i = 0; i < Depth; i++) begin
      slot = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (reg_mem_q[slot] == lookupRegister)) begin
        hit_c = 1'b1;
        val_c = val_mem_q[slot];
      end
    end
  end

  assign lookupHit   = hit_c;
  assign lookupValue = val_c;
`else
  logic unused_lookup;
  assign unused_lookup = ^lookupRegister;
  assign lookupHit     = 1'b0;
  assign lookupValue   = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue
//   Directed bench for writeback_queue (RegisterSize=32, Depth=4).
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_writeback_queue;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [3:0]  inRegister;
  logic [31:0] inValue;
  logic        stall;
  logic        regWriteEnable;
  logic [3:0]  writeRegister;
  logic [31:0] writeValue;
  logic [2:0]  count;
  logic [3:0]  lookupRegister;
  logic        lookupHit;
  logic [31:0] lookupValue;

  int checks = 0;
  int errors = 0;

  writeback_queue #(
    .RegisterSize(32),
    .Depth(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inValid(inValid),
    .inReady(inReady),
    .inRegister(inRegister),
    .inValue(inValue),
    .stall(stall),
    .regWriteEnable(regWriteEnable),
    .writeRegister(writeRegister),
    .writeValue(writeValue),
    .count(count),
    .lookupRegister(lookupRegister),
    .lookupHit(lookupHit),
    .lookupValue(lookupValue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    inValid = 1'b0;
    inRegister = '0;
    inValue = '0;
    stall = 1'b0;
    lookupRegister = '0;
    #12;
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if (regWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", regWriteEnable); end
    checks++;
    if (writeRegister !== 4'd0 || writeValue !== 32'd0) begin
      errors++; $display("FAIL reset_wdata got %0d/%h want 0/0", writeRegister, writeValue);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (inReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", inReady); end
    checks++;
    if (lookupHit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", lookupHit); end
  endtask

  // Single push: written during cycle after edge 2 only.
  task automatic test_single();
    inValid = 1'b1; inRegister = 4'd3; inValue = 32'h0000ABCD;
    tick();                       // edge 1: push
    inValid = 1'b0;
    checks++;
    if (count !== 3'd1 || regWriteEnable !== 1'b0) begin
      errors++; $display("FAIL single_e1 got cnt=%0d we=%b want cnt=1 we=0", count, regWriteEnable);
    end
    tick();                       // edge 2: pop
    checks++;
    if (regWriteEnable !== 1'b1 || writeRegister !== 4'd3 || writeValue !== 32'h0000ABCD || count !== 3'd0) begin
      errors++; $display("FAIL single_e2 got we=%b r=%0d v=%h cnt=%0d want 1/3/0000abcd/0",
                         regWriteEnable, writeRegister, writeValue, count);
    end
    tick();                       // edge 3: idle, data holds
    checks++;
    if (regWriteEnable !== 1'b0 || writeRegister !== 4'd3 || writeValue !== 32'h0000ABCD) begin
      errors++; $display("FAIL single_e3 got we=%b r=%0d v=%h want 0/3/0000abcd",
                         regWriteEnable, writeRegister, writeValue);
    end
  endtask

  // Stalled fill to full, rejected 5th push, then in-order drain.
  task automatic test_stall_full();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1; inRegister = 4'(i + 1); inValue = 32'h100 + 32'(i);
      checks++;
      if (inReady !== (i < 4)) begin errors++; $display("FAIL full_ready%0d got %b want %b", i, inReady, (i < 4)); end
      tick();
    end
    inValid = 1'b0;
    checks++;
    if (count !== 3'd4 || inReady !== 1'b0 || regWriteEnable !== 1'b0) begin
      errors++; $display("FAIL full_state got cnt=%0d rdy=%b we=%b want 4/0/0", count, inReady, regWriteEnable);
    end
    stall = 1'b0;
    #1;
    checks++;
    if (inReady !== 1'b0) begin errors++; $display("FAIL full_norefill got %b want 0", inReady); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (regWriteEnable !== 1'b1 || writeRegister !== 4'(i + 1) || writeValue !== 32'h100 + 32'(i)
          || count !== 3'(3 - i)) begin
        errors++; $display("FAIL drain%0d got we=%b r=%0d v=%h cnt=%0d want 1/%0d/%h/%0d",
                           i, regWriteEnable, writeRegister, writeValue, count, i + 1, 32'h100 + 32'(i), 3 - i);
      end
    end
    tick();
    checks++;
    if (regWriteEnable !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL drain_end got we=%b cnt=%0d want 0/0", regWriteEnable, count);
    end
  endtask

  // Steady state with count=2: push and pop every edge, pointers wrap.
  task automatic test_back_to_back();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      inValid = 1'b1; inRegister = 4'(k); inValue = 32'hC0DE0000 + 32'(k);
      tick();
    end
    stall = 1'b0;
    for (int j = 0; j < 10; j++) begin
      inValid = 1'b1; inRegister = 4'(j + 2); inValue = 32'hC0DE0000 + 32'(j + 2);
      tick();
      checks++;
      if (count !== 3'd2 || regWriteEnable !== 1'b1 || writeRegister !== 4'(j)
          || writeValue !== 32'hC0DE0000 + 32'(j)) begin
        errors++; $display("FAIL b2b%0d got cnt=%0d we=%b r=%0d v=%h want 2/1/%0d/%h",
                           j, count, regWriteEnable, writeRegister, writeValue, j, 32'hC0DE0000 + 32'(j));
      end
    end
    inValid = 1'b0;
    for (int j = 10; j < 12; j++) begin
      tick();
      checks++;
      if (regWriteEnable !== 1'b1 || writeRegister !== 4'(j) || writeValue !== 32'hC0DE0000 + 32'(j)) begin
        errors++; $display("FAIL b2b_tail%0d got we=%b r=%0d v=%h want 1/%0d/%h",
                           j, regWriteEnable, writeRegister, writeValue, j, 32'hC0DE0000 + 32'(j));
      end
    end
    tick();
    checks++;
    if (regWriteEnable !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL b2b_end got we=%b cnt=%0d want 0/0", regWriteEnable, count);
    end
  endtask

  task automatic test_bypass();
    logic        exp_hit;
    logic [31:0] exp_val;
    stall = 1'b1;
    inValid = 1'b1; inRegister = 4'd7; inValue = 32'h11;
    tick();
    inRegister = 4'd7; inValue = 32'h22;
    tick();
    inValid = 1'b0;
    lookupRegister = 4'd7;
    #1;
`ifdef WB_BYPASS_EN
    exp_hit = 1'b1; exp_val = 32'h22;
`else
    exp_hit = 1'b0; exp_val = 32'h0;
`endif
    checks++;
    if (lookupHit !== exp_hit || lookupValue !== exp_val) begin
      errors++; $display("FAIL bypass_r7 got %b/%h want %b/%h", lookupHit, lookupValue, exp_hit, exp_val);
    end
    lookupRegister = 4'd8;
    #1;
    checks++;
    if (lookupHit !== 1'b0) begin errors++; $display("FAIL bypass_r8 got %b want 0", lookupHit); end
    lookupRegister = 4'd7;
    stall = 1'b0;
    tick();                       // output holds {7,0x11}, queue holds {7,0x22}
    checks++;
    if (lookupHit !== exp_hit || lookupValue !== exp_val) begin
      errors++; $display("FAIL bypass_mix got %b/%h want %b/%h", lookupHit, lookupValue, exp_hit, exp_val);
    end
    tick();                       // only the output register holds {7,0x22}
    checks++;
    if (lookupHit !== exp_hit || lookupValue !== exp_val) begin
      errors++; $display("FAIL bypass_out got %b/%h want %b/%h", lookupHit, lookupValue, exp_hit, exp_val);
    end
    tick();
    checks++;
    if (lookupHit !== 1'b0) begin errors++; $display("FAIL bypass_gone got %b want 0", lookupHit); end
    lookupRegister = 4'd0;
  endtask

  task automatic test_reset_mid_drain();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inRegister = 4'(9 + i); inValue = 32'hDEAD0000 + 32'(i);
      tick();
    end
    inValid = 1'b0;
    stall = 1'b0;
    tick();
    checks++;
    if (count !== 3'd3 || regWriteEnable !== 1'b1) begin
      errors++; $display("FAIL middrain_pre got cnt=%0d we=%b want 3/1", count, regWriteEnable);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || regWriteEnable !== 1'b0 || writeRegister !== 4'd0 || writeValue !== 32'd0) begin
      errors++; $display("FAIL middrain_async got cnt=%0d we=%b r=%0d v=%h want 0/0/0/0",
                         count, regWriteEnable, writeRegister, writeValue);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (regWriteEnable !== 1'b0 || count !== 3'd0 || inReady !== 1'b1) begin
        errors++; $display("FAIL middrain_post%0d got we=%b cnt=%0d rdy=%b want 0/0/1",
                           i, regWriteEnable, count, inReady);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_full();
    test_back_to_back();
    test_bypass();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
